rc_servo_commander: RTL and testbench

// - Sits between fport_radio and dynamixel_sync_write. Turns RC channel updates into sync-write commands for four servos.
// - The arm channel drives Torque Enable (address 64, 1 byte).
// - Channels 0-3 drive Goal Velocity (address 104, 4 bytes), re-sent periodically.
// - Owns the send handshake, so the top level only wires radio -> commander -> writer.

---
 rtl/rc_servo_commander.sv | 165 ++++++++++++++++
 tb/tb_rc_servo_commander.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc_servo_commander.sv
// rc_servo_commander: RC channel updates -> Dynamixel sync-write commands.
// Optional channel-timeout failsafe: define CMD_FAILSAFE_EN.
module rc_servo_commander #(
  parameter int clock_frequency = 12000000,
  parameter int update_hz       = 50,
  parameter int center          = 992,
  parameter int deadband        = 16,
  parameter int velocity_limit  = 265,
  parameter int arm_channel     = 4,
  parameter int arm_threshold   = 1400,
  parameter int timeout_ms      = 500
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        channel_changed,
  input  logic [3:0]  channel_index,
  input  logic [10:0] channel_value,
  input  logic        sending,
  output logic        send,
  output logic [15:0] address,
  output logic [15:0] data_len,
  output logic [31:0] value1,
  output logic [31:0] value2,
  output logic [31:0] value3,
  output logic [31:0] value4,
  output logic        armed,
  output logic        failsafe
);

  localparam logic [31:0] period_max =
    32'(clock_frequency / update_hz - 1);
  localparam logic [10:0] c11 = 11'(center);
  localparam logic signed [11:0] c12 = 12'(center);
  localparam logic signed [11:0] db12 = 12'(deadband);
  localparam logic signed [11:0] lim12 = 12'(velocity_limit);
  localparam logic [10:0] thr11 = 11'(arm_threshold);
  localparam logic [3:0] arm_idx = 4'(arm_channel);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT_START, WAIT_DONE
  } state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [31:0] period_cnt;
  logic        vel_pend;
  logic [10:0] ch [4];
  logic [10:0] ch_arm;
  logic        arm_req;
  logic        torque_pend;
  logic [31:0] vel [4];

  function automatic logic [31:0] vel_of(input logic [10:0] v);
    logic signed [11:0] d;
    logic signed [11:0] r;
    d = $signed({1'b0, v}) - c12;
    if (d >= -db12 && d <= db12) r = '0;
    else if (d > lim12) r = lim12;
    else if (d < -lim12) r = -lim12;
    else r = d;
    return {{20{r[11]}}, r};
  endfunction

  assign arm_req = (ch_arm > thr11) && !failsafe;
  assign torque_pend = arm_req != armed;

  always_comb begin
    for (int i = 0; i < 4; i++)
      vel[i] = failsafe ? 32'd0 : vel_of(ch[i]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      period_cnt <= '0;
      vel_pend   <= 1'b0;
      send       <= 1'b0;
      address    <= 16'd64;
      data_len   <= 16'd1;
      value1     <= '0;
      value2     <= '0;
      value3     <= '0;
      value4     <= '0;
      armed      <= 1'b0;
      ch_arm     <= c11;
      for (int i = 0; i < 4; i++) ch[i] <= c11;
    end else begin
      send <= 1'b0;
      if (channel_changed) begin
        if (channel_index < 4'd4)
          ch[channel_index[1:0]] <= channel_value;
        if (channel_index == arm_idx)
          ch_arm <= channel_value;
      end
      if (period_cnt == period_max) begin
        period_cnt <= '0;
        vel_pend   <= 1'b1;
      end else begin
        period_cnt <= period_cnt + 32'd1;
      end
      unique case (state)
        IDLE: if (!sending) begin
          if (torque_pend) begin
            address  <= 16'd64;
            data_len <= 16'd1;
            value1   <= {31'd0, arm_req};
            value2   <= {31'd0, arm_req};
            value3   <= {31'd0, arm_req};
            value4   <= {31'd0, arm_req};
            armed    <= arm_req;
            state    <= ISSUE;
          end else if (vel_pend) begin
            // served or dropped; a disarmed request is discarded
            vel_pend <= 1'b0;
            if (armed) begin
              address  <= 16'd104;
              data_len <= 16'd4;
              value1   <= vel[0];
              value2   <= vel[1];
              value3   <= vel[2];
              value4   <= vel[3];
              state    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          send     <= 1'b1;
          wait_cnt <= '0;
          state    <= WAIT_START;
        end
        WAIT_START: begin
          if (sending) state <= WAIT_DONE;
          else if (wait_cnt == 4'd15) state <= IDLE;
          else wait_cnt <= wait_cnt + 4'd1;
        end
        WAIT_DONE: if (!sending) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CMD_FAILSAFE_EN
  localparam logic [31:0] timeout_max =
    32'(clock_frequency / 1000 * timeout_ms - 1);
  logic [31:0] to_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      to_cnt   <= '0;
      failsafe <= 1'b0;
    end else if (channel_changed) begin
      to_cnt   <= '0;
      failsafe <= 1'b0;
    end else if (to_cnt == timeout_max) begin
      failsafe <= 1'b1;
    end else begin
      to_cnt <= to_cnt + 32'd1;
    end
  end
`else
  assign failsafe = 1'b0;
`endif

endmodule

// File: tb/tb_rc_servo_commander.sv
// tb_rc_servo_commander: randomized self-checking bench for the
// RC servo commander, with a writer responder and send monitor.
module tb_rc_servo_commander;

  logic        clock;
  logic        reset;
  logic        channel_changed;
  logic [3:0]  channel_index;
  logic [10:0] channel_value;
  logic        sending;
  logic        send;
  logic [15:0] address;
  logic [15:0] data_len;
  logic [31:0] value1, value2, value3, value4;
  logic        armed;
  logic        failsafe;

  rc_servo_commander #(
    .clock_frequency(1000),
    .update_hz(10),
    .timeout_ms(2000)
  ) dut (
    .clock(clock),
    .reset(reset),
    .channel_changed(channel_changed),
    .channel_index(channel_index),
    .channel_value(channel_value),
    .sending(sending),
    .send(send),
    .address(address),
    .data_len(data_len),
    .value1(value1),
    .value2(value2),
    .value3(value3),
    .value4(value4),
    .armed(armed),
    .failsafe(failsafe)
  );

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [15:0] len;
    logic [31:0] v [4];
  } rec_t;

  rec_t q [$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   s_cyc = 0;
  int   wmode = 0;
  int   busy_len = 5;
  logic man_sending = 0;
  logic auto_sending = 0;
  int   m [4];
  int   m_arm;

  assign sending = (wmode == 1) ? man_sending : auto_sending;

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc = cyc + 1;

  always @(negedge clock) begin
    rec_t r;
    if (send === 1'b1) begin
      r.cyc  = cyc;
      r.addr = address;
      r.len  = data_len;
      r.v[0] = value1;
      r.v[1] = value2;
      r.v[2] = value3;
      r.v[3] = value4;
      q.push_back(r);
    end
  end

  // writer model: busy for busy_len cycles after each send
  initial begin
    forever begin
      @(negedge clock);
      if (wmode == 0 && send === 1'b1) begin
        auto_sending = 1;
        repeat (busy_len) @(negedge clock);
        auto_sending = 0;
      end
    end
  end

  function automatic int ref_vel(input int v);
    int d;
    d = v - 992;
    if (d >= -16 && d <= 16) return 0;
    if (d > 265) return 265;
    if (d < -265) return -265;
    return d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d (0x%h) required %0d (0x%h)",
             tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  task automatic chk_true(input string tag, input bit cond,
                          input int obs);
    tests++;
    assert (cond) else begin
      fails++;
      $error("FAIL %s: condition violated, observed %0d", tag, obs);
    end
  endtask

  task automatic get_rec(input string tag, input int budget,
                         output rec_t r);
    int n;
    bit ok;
    n = 0;
    while (q.size() == 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    ok = (q.size() > 0);
    tests++;
    assert (ok) else begin
      fails++;
      $error("FAIL %s: got no send in %0d cycles, required one",
             tag, budget);
    end
    if (ok) r = q.pop_front();
    else begin
      r.cyc = 0; r.addr = 'x; r.len = 'x;
      for (int i = 0; i < 4; i++) r.v[i] = 'x;
    end
  endtask

  task automatic check_torque(input string tag, input rec_t r,
                              input int val);
    chk({tag, ".addr"}, 32'(r.addr), 32'd64);
    chk({tag, ".len"}, 32'(r.len), 32'd1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s.v%0d", tag, i + 1), r.v[i], 32'(val));
  endtask

  task automatic check_vel(input string tag, input rec_t r);
    chk({tag, ".addr"}, 32'(r.addr), 32'd104);
    chk({tag, ".len"}, 32'(r.len), 32'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s.v%0d", tag, i + 1), r.v[i],
          32'(ref_vel(m[i])));
  endtask

  task automatic strobe(input int idx, input int val);
    @(negedge clock);
    s_cyc = cyc;
    channel_changed = 1;
    channel_index = 4'(idx);
    channel_value = 11'(val);
    @(negedge clock);
    channel_changed = 0;
    if (idx < 4) m[idx] = val;
    if (idx == 4) m_arm = val;
  endtask

  task automatic set4(input int a, input int b, input int c,
                      input int d);
    strobe(0, a);
    strobe(1, b);
    strobe(2, c);
    strobe(3, d);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".send"}, 32'(send), 32'd0);
    chk({tag, ".addr"}, 32'(address), 32'd64);
    chk({tag, ".len"}, 32'(data_len), 32'd1);
    chk({tag, ".v1"}, value1, 32'd0);
    chk({tag, ".v2"}, value2, 32'd0);
    chk({tag, ".v3"}, value3, 32'd0);
    chk({tag, ".v4"}, value4, 32'd0);
    chk({tag, ".armed"}, 32'(armed), 32'd0);
    chk({tag, ".fs"}, 32'(failsafe), 32'd0);
  endtask

  initial begin
    rec_t r;
    int   t0;
    int   c0;
    int   n;
    channel_changed = 0;
    channel_index = 0;
    channel_value = 0;
    for (int i = 0; i < 4; i++) m[i] = 992;
    m_arm = 992;

    reset = 1;
    repeat (3) @(negedge clock);
    check_reset("rst");
    reset = 0;

    strobe(4, 1800);
    get_rec("arm", 10, r);
    check_torque("arm", r, 1);
    chk("arm.lat", 32'(r.cyc - s_cyc), 32'd3);
    chk("arm.armed", 32'(armed), 32'd1);

    get_rec("sync0", 150, r);
    check_vel("sync0", r);
    set4(1500, 992, 1000, 100);
    get_rec("dir0", 150, r);
    check_vel("dir0", r);
    chk("dir0.exact4", r.v[3], 32'hFFFF_FEF7);
    set4(1008, 1009, 1257, 1258);
    get_rec("bnd_hi", 150, r);
    check_vel("bnd_hi", r);
    set4(976, 975, 727, 726);
    get_rec("bnd_lo", 150, r);
    check_vel("bnd_lo", r);

    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 1) == 0)
          strobe(i, int'($urandom_range(0, 2047)));
        else
          strobe(i, int'($urandom_range(992 - 300, 992 + 300)));
      end
      strobe(int'($urandom_range(5, 15)),
             int'($urandom_range(0, 2047)));
      get_rec($sformatf("rnd%0d", k), 150, r);
      check_vel($sformatf("rnd%0d", k), r);
    end

    repeat (10) @(negedge clock);
    wmode = 1;
    man_sending = 1;
    strobe(4, 1000);
    repeat (200) @(negedge clock);
    chk("hold.nosend", 32'(q.size()), 32'd0);
    man_sending = 0;
    c0 = cyc;
    get_rec("hold.dis", 5, r);
    check_torque("hold.dis", r, 0);
    chk("hold.lat", 32'(r.cyc - c0), 32'd2);
    wmode = 0;
    repeat (250) @(negedge clock);
    chk("disarmed.nosend", 32'(q.size()), 32'd0);
    chk("disarmed.armed", 32'(armed), 32'd0);

    wmode = 2;
    strobe(4, 1800);
    get_rec("silent.arm", 10, r);
    check_torque("silent.arm", r, 1);
    t0 = r.cyc;
    get_rec("silent.vel", 150, r);
    check_vel("silent.vel", r);
    chk_true("silent.gap", (r.cyc - t0) >= 17, r.cyc - t0);

    wmode = 1;
    man_sending = 0;
    get_rec("wd.sync", 150, r);
    check_vel("wd.sync", r);
    man_sending = 1;
    repeat (3) @(negedge clock);
    reset = 1;
    @(negedge clock);
    check_reset("wd.rst");
    reset = 0;
    man_sending = 0;
    q.delete();
    for (int i = 0; i < 4; i++) m[i] = 992;
    m_arm = 992;
    wmode = 0;
    repeat (250) @(negedge clock);
    chk("wd.nosend", 32'(q.size()), 32'd0);

`ifdef CMD_FAILSAFE_EN
    strobe(4, 1800);
    get_rec("fs.arm", 10, r);
    check_torque("fs.arm", r, 1);
    n = 0;
    while (failsafe !== 1'b1 && n < 2500) begin
      @(negedge clock);
      n++;
    end
    chk("fs.set", 32'(failsafe), 32'd1);
    q.delete();
    get_rec("fs.dis", 20, r);
    if (r.addr === 16'd104) get_rec("fs.dis2", 20, r);
    check_torque("fs.dis", r, 0);
    repeat (300) @(negedge clock);
    chk("fs.nosend", 32'(q.size()), 32'd0);
    chk("fs.armed", 32'(armed), 32'd0);
    strobe(0, 992);
    chk("fs.clear", 32'(failsafe), 32'd0);
    get_rec("fs.rearm", 10, r);
    check_torque("fs.rearm", r, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
